encap_ctrl: RTL and testbench
=============================

ENCAP_CTRL -- requirements
Module: encap_ctrl

Interface
REQ-001 Parameter N, default 47, ring degree n of GF(2^m)[z].
REQ-002 Parameter M, default 79, field degree m of GF(2^m).
REQ-003 Parameter D, default 5, GF(2^m) elements per memory row; WIDTH = M*D; DEPTH = ceil(N/D); AW = clog2(DEPTH).
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst_b  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  one-cycle request to run ROLLO-I encapsulation.
REQ-007 finish  out  1  one-cycle pulse, encapsulation complete.
REQ-008 status  out  3  phase: 0 idle, 1 support gen, 2 error gen, 3 multiply, 4 add, 5 hash.
REQ-009 supp_start / supp_done  out / in  1 each  handshake to error-support generator.
REQ-010 egen_start / egen_done  out / in  1 each  handshake to e1/e2 vector generator.
REQ-011 mul_start / mul_done  out / in  1 each  handshake to gf2mz multiplier (p = e2*h).
REQ-012 sha3_start / sha3_done  out / in  1 each  handshake to keccak hashing support E.
REQ-013 e1_addr  out  AW  row address into e1 memory; e1_din  in  WIDTH  read data.
REQ-014 p_addr  out  AW  row address into product memory; p_din  in  WIDTH  read data.
REQ-015 c_addr  out  AW, c_dout  out  WIDTH, c_we  out  1  write port of ciphertext memory.

Function
REQ-016 FSM states IDLE, SUPP, EGEN, MUL, ADD, HASH, FIN; status encodes as REQ-008 (FIN reports 5).
REQ-017 IDLE: start=1 -> SUPP; start ignored in every other state.
REQ-018 Each *_start pulses high exactly one cycle, the first cycle after entering its state.
REQ-019 SUPP waits supp_done -> EGEN; EGEN waits egen_done -> MUL; MUL waits mul_done -> ADD.
REQ-020 A *_done is honoured only in its own state, earliest the cycle after the matching *_start; done seen elsewhere ignored, no state change.
REQ-021 ADD: read counter k = 0..DEPTH-1 drives e1_addr = p_addr = k, one row per cycle.
REQ-022 Memories have 1-cycle read latency; cycle after issuing k: c_addr = k, c_dout = e1_din XOR p_din, c_we = 1.
REQ-023 ADD lasts exactly DEPTH+1 cycles; last write is row DEPTH-1; then -> HASH.
REQ-024 Unused tail elements of last row are XORed as-is, no masking (memories pre-zeroed).
REQ-025 HASH waits sha3_done -> FIN; FIN asserts finish one cycle -> IDLE.
REQ-026 c_we high only in the DEPTH write cycles of ADD; c_dout and addresses hold 0 when not in ADD.
REQ-027 start in the FIN cycle ignored; new run needs start while in IDLE.
REQ-028 No timeout: FSM waits indefinitely for any done.

Reset
REQ-029 rst_b=1 at a clock edge -> IDLE; finish, status, all *_start, c_we, all addresses, c_dout = 0.
REQ-030 Reset mid-operation (any state incl. mid-ADD) aborts next edge; no further c_we; stray done inputs afterwards ignored.

Verification
REQ-031 Nominal: start, each done 3 cycles after its start -> status 1,2,3,4,5 in order, finish one pulse, 4 *_start pulses total.
REQ-032 ADD data: e1 row k = k, p row k = {WIDTH{1}} -> c rows 0..9 written = ~k, c_we high exactly 10 cycles (DEPTH=10).
REQ-033 Spurious: mul_done pulsed during SUPP and sha3_done during ADD -> no state change, sequence completes normally.
REQ-034 start held high 40 cycles -> exactly one run, no re-trigger before IDLE; start re-pulsed after finish -> second identical run.
REQ-035 Reset asserted at ADD row 4 -> next cycle status 0, c_we 0, later done pulses produce no start/finish.
REQ-036 Done asserted same cycle as its start -> ignored; FSM advances only on later done.

Source files
------------

// File: rtl/encap_ctrl.sv
// ROLLO-I encapsulation sequencer: steps the support/error/multiply/hash cores
// and XORs e1 with p = e2*h row by row into the ciphertext memory.
module encap_ctrl #(
  parameter int N = 47,
  parameter int M = 79,
  parameter int D = 5,
  localparam int WIDTH = M * D,
  localparam int DEPTH = (N + D - 1) / D,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  output logic             finish,
  output logic [2:0]       status,
  output logic [2:0]       dbg_state,
  output logic             supp_start,
  input  logic             supp_done,
  output logic             egen_start,
  input  logic             egen_done,
  output logic             mul_start,
  input  logic             mul_done,
  output logic             sha3_start,
  input  logic             sha3_done,
  output logic [AW-1:0]    e1_addr,
  input  logic [WIDTH-1:0] e1_din,
  output logic [AW-1:0]    p_addr,
  input  logic [WIDTH-1:0] p_din,
  output logic [AW-1:0]    c_addr,
  output logic [WIDTH-1:0] c_dout,
  output logic             c_we
);

  // Handshakes: each *_start is a one-cycle pulse in the first cycle of its
  // state; the matching *_done is a level sampled only in that state and only
  // from the cycle after the start pulse onward, so a done that coincides with
  // its start (or arrives in any other state) is ignored.

  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SUPP = 3'd1,
    S_EGEN = 3'd2,
    S_MUL  = 3'd3,
    S_ADD  = 3'd4,
    S_HASH = 3'd5,
    S_FIN  = 3'd6
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_entry;
  logic [CW-1:0]   r_k;
  logic            r_we;
  logic [AW-1:0]   r_waddr;
  logic            w_issue;

  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_state <= S_IDLE;
      r_entry <= 1'b0;
    end else begin
      r_state <= w_next;
      r_entry <= (w_next != r_state);
    end
  end

  always_comb begin
    w_next     = r_state;
    status     = 3'd0;
    finish     = 1'b0;
    supp_start = 1'b0;
    egen_start = 1'b0;
    mul_start  = 1'b0;
    sha3_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_SUPP;
      end
      S_SUPP: begin
        status     = 3'd1;
        supp_start = r_entry;
        if (supp_done && !r_entry) w_next = S_EGEN;
      end
      S_EGEN: begin
        status     = 3'd2;
        egen_start = r_entry;
        if (egen_done && !r_entry) w_next = S_MUL;
      end
      S_MUL: begin
        status    = 3'd3;
        mul_start = r_entry;
        if (mul_done && !r_entry) w_next = S_ADD;
      end
      S_ADD: begin
        status = 3'd4;
        if (r_k == CW'(DEPTH)) w_next = S_HASH;
      end
      S_HASH: begin
        status     = 3'd5;
        sha3_start = r_entry;
        if (sha3_done && !r_entry) w_next = S_FIN;
      end
      S_FIN: begin
        status = 3'd5;
        finish = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign dbg_state = r_state;

  // Read rows 0..DEPTH-1 on consecutive ADD cycles; the final ADD cycle only
  // drains the last read into the ciphertext memory.
  assign w_issue = (r_state == S_ADD) && (r_k < CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_k     <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
    end else begin
      r_k     <= w_issue ? r_k + CW'(1) : '0;
      r_we    <= w_issue;
      r_waddr <= w_issue ? r_k[AW-1:0] : '0;
    end
  end

  always_comb begin
    e1_addr = '0;
    p_addr  = '0;
    if (w_issue) begin
      e1_addr = r_k[AW-1:0];
      p_addr  = r_k[AW-1:0];
    end
  end

  // Tail elements of the last row are XORed unmasked; memories are pre-zeroed.
  assign c_we   = r_we;
  assign c_addr = r_waddr;
  assign c_dout = r_we ? (e1_din ^ p_din) : '0;

endmodule

// File: tb/tb_encap_ctrl.sv
// Directed bench for encap_ctrl: full runs with hand-derived phase timing,
// spurious/same-cycle done pulses, held start and reset in the middle of ADD.
module tb_encap_ctrl;
  localparam int N     = 47;
  localparam int M     = 79;
  localparam int D     = 5;
  localparam int W     = M * D;
  localparam int DEPTH = 10;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_b, start;
  logic          finish;
  logic [2:0]    status, dbg_state;
  logic          supp_start, supp_done, egen_start, egen_done;
  logic          mul_start, mul_done, sha3_start, sha3_done;
  logic [AW-1:0] e1_addr, p_addr, c_addr;
  logic [W-1:0]  e1_din, p_din, c_dout;
  logic          c_we;

  logic [W-1:0]  e1_mem [0:15];
  logic [W-1:0]  p_mem  [0:15];

  int errors = 0;
  int checks = 0;
  int n_supp = 0, n_egen = 0, n_mul = 0, n_sha = 0, n_fin = 0, n_we = 0;

  encap_ctrl #(.N(N), .M(M), .D(D)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .finish(finish),
    .status(status), .dbg_state(dbg_state),
    .supp_start(supp_start), .supp_done(supp_done),
    .egen_start(egen_start), .egen_done(egen_done),
    .mul_start(mul_start), .mul_done(mul_done),
    .sha3_start(sha3_start), .sha3_done(sha3_done),
    .e1_addr(e1_addr), .e1_din(e1_din),
    .p_addr(p_addr), .p_din(p_din),
    .c_addr(c_addr), .c_dout(c_dout), .c_we(c_we)
  );

  // Clock, synchronous-read memory models and pulse counters
  always #5 clk = ~clk;

  always @(posedge clk) begin
    e1_din <= e1_mem[e1_addr];
    p_din  <= p_mem[p_addr];
  end

  always @(posedge clk) begin
    if (supp_start === 1'b1) n_supp++;
    if (egen_start === 1'b1) n_egen++;
    if (mul_start === 1'b1)  n_mul++;
    if (sha3_start === 1'b1) n_sha++;
    if (finish === 1'b1)     n_fin++;
    if (c_we === 1'b1)       n_we++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic sel_start(input int ph);
    case (ph)
      1: return supp_start;
      2: return egen_start;
      3: return mul_start;
      default: return sha3_start;
    endcase
  endfunction

  task automatic set_done(input int ph, input logic v);
    case (ph)
      1: supp_done = v;
      2: egen_done = v;
      3: mul_done  = v;
      default: sha3_done = v;
    endcase
  endtask

  // Waits for the phase's start pulse, checks it, then answers with done.
  // mode 1: spurious mul_done in SUPP; mode 3: done raised alongside start.
  task automatic handle_phase(input int ph, input int mode, input int dly);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (sel_start(ph) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL start_timeout ph%0d: no start pulse within 100 cycles", ph);
    end
    checks++;
    if (status !== 3'(ph)) begin
      errors++;
      $display("FAIL phase_status ph%0d: got %0d expected %0d", ph, status, ph);
    end
    if (mode == 3) begin
      set_done(ph, 1'b1);
      tick();
      set_done(ph, 1'b0);
      checks++;
      if (status !== 3'(ph)) begin
        errors++;
        $display("FAIL same_cycle_done ph%0d: status %0d expected %0d", ph, status, ph);
      end
    end else begin
      tick();
    end
    checks++;
    if (sel_start(ph) !== 1'b0) begin
      errors++;
      $display("FAIL start_one_cycle ph%0d: start still %b expected 0", ph, sel_start(ph));
    end
    if (mode == 1 && ph == 1) begin
      mul_done = 1'b1;
      tick();
      mul_done = 1'b0;
      checks++;
      if (status !== 3'd1) begin
        errors++;
        $display("FAIL spurious_mul_done: status %0d expected 1", status);
      end
    end
    repeat (dly - 1) tick();
    set_done(ph, 1'b1);
    tick();
    set_done(ph, 1'b0);
  endtask

  // mode 0 nominal, 1 spurious dones, 2 start held 40 cycles,
  // 3 done coincident with start, 4 reset at ADD row 4
  task automatic run(input int mode, input int dly);
    int s_supp, s_egen, s_mul, s_sha, s_fin, s_we;
    logic [W-1:0]  kv;
    logic [W-1:0]  exp_dout;
    logic [AW-1:0] exp_addr;
    s_supp = n_supp; s_egen = n_egen; s_mul = n_mul;
    s_sha = n_sha; s_fin = n_fin; s_we = n_we;
    start = 1'b1;
    tick();
    if (mode == 2) begin
      fork
        begin
          repeat (40) tick();
          start = 1'b0;
        end
      join_none
    end else begin
      start = 1'b0;
    end
    for (int ph = 1; ph <= 3; ph++) handle_phase(ph, mode, dly);

    for (int cyc = 0; cyc <= DEPTH; cyc++) begin
      exp_addr = (cyc < DEPTH) ? AW'(cyc) : '0;
      kv = '0;
      if (cyc > 0) kv[AW-1:0] = AW'(cyc - 1);
      exp_dout = (cyc > 0) ? ~kv : '0;
      checks++;
      if (status !== 3'd4) begin
        errors++;
        $display("FAIL add_status cyc%0d: got %0d expected 4", cyc, status);
      end
      checks++;
      if (e1_addr !== exp_addr || p_addr !== exp_addr) begin
        errors++;
        $display("FAIL add_rd_addr cyc%0d: e1 %0d p %0d expected %0d", cyc, e1_addr, p_addr, exp_addr);
      end
      checks++;
      if (c_we !== (cyc > 0)) begin
        errors++;
        $display("FAIL add_we cyc%0d: got %b expected %b", cyc, c_we, (cyc > 0));
      end
      checks++;
      if (c_addr !== kv[AW-1:0] || c_dout !== exp_dout) begin
        errors++;
        $display("FAIL add_wr cyc%0d: addr %0d dout %0h expected addr %0d dout %0h",
                 cyc, c_addr, c_dout, kv[AW-1:0], exp_dout);
      end
      if (mode == 4 && cyc == 4) begin
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        checks++;
        if (status !== 3'd0 || c_we !== 1'b0 || c_dout !== '0 || c_addr !== '0 || e1_addr !== '0) begin
          errors++;
          $display("FAIL mid_add_reset: status %0d we %b addr %0d dout %0h e1 %0d expected all 0",
                   status, c_we, c_addr, c_dout, e1_addr);
        end
        return;
      end
      if (mode == 1) sha3_done = (cyc == 5);
      tick();
    end
    sha3_done = 1'b0;

    handle_phase(5, mode, dly);
    checks++;
    if (finish !== 1'b1 || status !== 3'd5) begin
      errors++;
      $display("FAIL fin: finish %b status %0d expected 1 and 5", finish, status);
    end
    if (mode != 2) start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (finish !== 1'b0 || status !== 3'd0) begin
      errors++;
      $display("FAIL after_fin: finish %b status %0d expected 0 and 0", finish, status);
    end
    tick();
    checks++;
    if (status !== 3'd0 || supp_start !== 1'b0) begin
      errors++;
      $display("FAIL start_in_fin: status %0d supp_start %b expected 0 and 0", status, supp_start);
    end
    checks++;
    if (n_supp - s_supp != 1 || n_egen - s_egen != 1 || n_mul - s_mul != 1 ||
        n_sha - s_sha != 1 || n_fin - s_fin != 1) begin
      errors++;
      $display("FAIL pulse_counts m%0d: supp %0d egen %0d mul %0d sha %0d fin %0d expected 1 each",
               mode, n_supp - s_supp, n_egen - s_egen, n_mul - s_mul, n_sha - s_sha, n_fin - s_fin);
    end
    checks++;
    if (n_we - s_we != DEPTH) begin
      errors++;
      $display("FAIL we_count m%0d: got %0d expected %0d", mode, n_we - s_we, DEPTH);
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b1;
    start = 1'b0;
    supp_done = 1'b0; egen_done = 1'b0; mul_done = 1'b0; sha3_done = 1'b0;
    repeat (3) tick();
    checks++;
    if (status !== 3'd0 || finish !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: status %0d finish %b expected 0 and 0", status, finish);
    end
    checks++;
    if ({supp_start, egen_start, mul_start, sha3_start} !== 4'b0) begin
      errors++;
      $display("FAIL reset_starts: got %b expected 0000", {supp_start, egen_start, mul_start, sha3_start});
    end
    checks++;
    if (c_we !== 1'b0 || c_dout !== '0 || c_addr !== '0 || e1_addr !== '0 || p_addr !== '0) begin
      errors++;
      $display("FAIL reset_mem_port: we %b dout %0h c %0d e1 %0d p %0d expected 0",
               c_we, c_dout, c_addr, e1_addr, p_addr);
    end
    rst_b = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_add();
    int s_starts, s_fin;
    run(4, 3);
    s_starts = n_supp + n_egen + n_mul + n_sha;
    s_fin = n_fin;
    for (int i = 0; i < 16; i++) begin
      supp_done = (i == 1);
      egen_done = (i == 4);
      mul_done  = (i == 7);
      sha3_done = (i == 10);
      tick();
      checks++;
      if (status !== 3'd0 || c_we !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle i%0d: status %0d we %b expected 0 and 0", i, status, c_we);
      end
    end
    supp_done = 1'b0; egen_done = 1'b0; mul_done = 1'b0; sha3_done = 1'b0;
    checks++;
    if (n_supp + n_egen + n_mul + n_sha != s_starts || n_fin != s_fin) begin
      errors++;
      $display("FAIL stray_done: starts +%0d finish +%0d expected 0 and 0",
               n_supp + n_egen + n_mul + n_sha - s_starts, n_fin - s_fin);
    end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      e1_mem[k] = '0;
      e1_mem[k][AW-1:0] = AW'(k);
      p_mem[k] = (k < DEPTH) ? '1 : '0;
    end
    test_reset();
    run(0, 3);          // nominal
    run(1, 3);          // spurious done pulses
    run(2, 8);          // start held 40 cycles
    run(0, 3);          // re-pulsed start, identical second run
    run(3, 3);          // done coincident with start
    test_reset_mid_add();
    run(0, 3);          // recovery after abort
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
